alu_select_sequencer: RTL and testbench

//   Upstream control stage for the ALU result multiplexer. Accepts opcodes over a valid/ready

---
 rtl/alu_select_sequencer_pkg.sv | 32 +++
 rtl/alu_select_sequencer_if.sv | 44 ++++
 rtl/alu_select_sequencer_onehot_decoder.sv | 22 ++
 rtl/alu_select_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_select_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/alu_select_sequencer_pkg.sv
// ============================================================================
// Module : alu_select_sequencer_pkg
// Brief  : Shared opcode channels, FSM state encoding and defaults for the
//          ALU select sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_select_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd14;
  localparam logic [3:0] OP_DIV = 4'd15;

  localparam logic [15:0] DEFAULT_MC_MASK = 16'hC000;

endpackage

`default_nettype wire

// File: rtl/alu_select_sequencer_if.sv
// ============================================================================
// Module : alu_select_sequencer_if
// Brief  : Opcode/result handshake bundle between op source, sequencer and
//          result consumer. err exists only with ALU_SEQ_ILLEGAL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_select_sequencer_if #(
  parameter int OP_W  = 4,
  parameter int SEL_W = 16
);
  import alu_select_sequencer_pkg::*;

  logic             op_valid;
  logic             op_ready;
  logic [OP_W-1:0]  op_code;
  logic [SEL_W-1:0] sel;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
`ifdef ALU_SEQ_ILLEGAL_EN
  logic             err;
`endif

  modport master (
    output op_valid, op_code, res_ready,
`ifdef ALU_SEQ_ILLEGAL_EN
    input  err,
`endif
    input  op_ready, sel, res_valid, busy
  );

  modport slave (
    input  op_valid, op_code, res_ready,
`ifdef ALU_SEQ_ILLEGAL_EN
    output err,
`endif
    output op_ready, sel, res_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/alu_select_sequencer_onehot_decoder.sv
// ============================================================================
// Module : onehot_decoder
// Brief  : Combinational binary-to-one-hot decoder (1 << code).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module onehot_decoder #(
  parameter int OP_W  = 4,
  parameter int SEL_W = 16
) (
  input  logic [OP_W-1:0]  code,
  output logic [SEL_W-1:0] onehot
);

  for (genvar i = 0; i < SEL_W; i++) begin : g_bit
    assign onehot[i] = (code == OP_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/alu_select_sequencer.sv
// ============================================================================
// Module : alu_select_sequencer
// Brief  : Accepts opcodes, drives a held one-hot mux select for the op's
//          latency and hands the result off. Option: ALU_SEQ_ILLEGAL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_select_sequencer
  import alu_select_sequencer_pkg::*;
#(
  parameter int               OP_W      = 4,
  parameter int               SEL_W     = 16,
  parameter int               MC_CYCLES = 4,
  parameter logic [SEL_W-1:0] MC_MASK   = DEFAULT_MC_MASK
`ifdef ALU_SEQ_ILLEGAL_EN
  ,
  parameter logic [SEL_W-1:0] ILL_MASK  = 16'h0000
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_select_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ALU_SEQ_ILLEGAL_EN
  logic             err_q, err_d;
`endif

  logic [SEL_W-1:0] dec_sel;
  logic             op_ready;
  logic             accept;

  onehot_decoder #(
    .OP_W  (OP_W),
    .SEL_W (SEL_W)
  ) u_dec (
    .code   (bus.op_code),
    .onehot (dec_sel)
  );

  // HOLD with res_ready frees the slot in the same cycle, so ops stream back-to-back.
  assign op_ready = (state_q == IDLE) | ((state_q == HOLD) & bus.res_ready);
  assign accept   = bus.op_valid & op_ready;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
`ifdef ALU_SEQ_ILLEGAL_EN
    err_d       = err_q;
`endif

    case (state_q)
      EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          sel_d       = '0;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_EN
          err_d       = 1'b0;
`endif
        end
      end
      IDLE:    ;
      default: state_d = IDLE;
    endcase

    // A new op overrides the hand-off above, whether from IDLE or HOLD.
    if (accept) begin
      sel_d  = dec_sel;
      busy_d = 1'b1;
      if (MC_MASK[bus.op_code]) begin
        state_d     = EXEC;
        res_valid_d = 1'b0;
        cnt_d       = CNT_W'(MC_CYCLES - 1);
      end else begin
        state_d     = HOLD;
        res_valid_d = 1'b1;
      end
`ifdef ALU_SEQ_ILLEGAL_EN
      err_d = 1'b0;
      if (ILL_MASK[bus.op_code]) begin
        sel_d       = '0;
        state_d     = HOLD;
        res_valid_d = 1'b1;
        err_d       = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
`ifdef ALU_SEQ_ILLEGAL_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
`ifdef ALU_SEQ_ILLEGAL_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.op_ready  = op_ready;
  assign bus.sel       = sel_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
`ifdef ALU_SEQ_ILLEGAL_EN
  assign bus.err       = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_select_sequencer.sv
// ============================================================================
// Module : tb_alu_select_sequencer
// Brief  : Directed plus random stimulus against a transaction-level model
//          (pending op + ready time stamp). Honours ALU_SEQ_ILLEGAL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_select_sequencer;

  localparam int          OP_W      = 4;
  localparam int          SEL_W     = 16;
  localparam int          MC_CYCLES = 4;
  localparam logic [15:0] MC_MASK   = 16'hC000;
`ifdef ALU_SEQ_ILLEGAL_EN
  localparam logic [15:0] ILL_MASK  = 16'h0100;
`else
  localparam logic [15:0] ILL_MASK  = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_select_sequencer_if #(.OP_W(OP_W), .SEL_W(SEL_W)) bus ();

  alu_select_sequencer #(
    .OP_W      (OP_W),
    .SEL_W     (SEL_W),
    .MC_CYCLES (MC_CYCLES),
    .MC_MASK   (MC_MASK)
`ifdef ALU_SEQ_ILLEGAL_EN
    ,
    .ILL_MASK  (ILL_MASK)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: at most one op in flight; result visible from cycle m_rdy until taken.
  bit m_have;
  int m_code;
  int m_rdy;
  int cyc;
  int n_vec;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit is_ill(input int code);
    logic [15:0] m;
    m = ILL_MASK;
    return m[code];
  endfunction

  function automatic int latency(input int code);
    logic [15:0] m;
    m = MC_MASK;
    if (is_ill(code)) return 1;
    return m[code] ? MC_CYCLES : 1;
  endfunction

  function automatic logic [15:0] exp_sel();
    logic [15:0] r;
    r = '0;
    if (m_have && !is_ill(m_code)) r[m_code] = 1'b1;
    return r;
  endfunction

  // Called just after a falling edge: check registered outputs, drive inputs, check op_ready.
  task automatic step(input logic v, input logic [3:0] code, input logic rr);
    logic exp_rv, exp_rdy;
    exp_rv = m_have && (cyc >= m_rdy);
    check_eq("sel", bus.sel, exp_sel());
    check_eq("res_valid", bus.res_valid, exp_rv);
    check_eq("busy", bus.busy, m_have);
`ifdef ALU_SEQ_ILLEGAL_EN
    check_eq("err", bus.err, m_have && is_ill(m_code));
`endif
    bus.op_valid  = v;
    bus.op_code   = code;
    bus.res_ready = rr;
    #1;
    exp_rdy = !m_have || (exp_rv && rr);
    check_eq("op_ready", bus.op_ready, exp_rdy);
    if (v && exp_rdy) begin
      m_have = 1'b1;
      m_code = int'(code);
      m_rdy  = cyc + latency(int'(code));
    end else if (exp_rv && rr) begin
      m_have = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    m_have = 1'b0; m_code = 0; m_rdy = 0;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_sel", bus.sel, 16'h0000);
    check_eq("rst_res_valid", bus.res_valid, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_op_ready", bus.op_ready, 1'b1);

    // single-cycle op 5
    step(1'b1, 4'd5, 1'b1);
    check_eq("sc_sel", bus.sel, 16'h0020);
    check_eq("sc_res_valid", bus.res_valid, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    check_eq("sc_idle_sel", bus.sel, 16'h0000);
    step(1'b0, 4'd0, 1'b0);

    // multi-cycle op 15; res_ready during EXEC must be ignored
    step(1'b1, 4'd15, 1'b0);
    repeat (3) step(1'b0, 4'd0, 1'b1);
    check_eq("mc_sel", bus.sel, 16'h8000);
    check_eq("mc_res_valid", bus.res_valid, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    // back-to-back stream 2,3,1
    step(1'b1, 4'd2, 1'b1);
    check_eq("b2b_sel0", bus.sel, 16'h0004);
    step(1'b1, 4'd3, 1'b1);
    check_eq("b2b_sel1", bus.sel, 16'h0008);
    step(1'b1, 4'd1, 1'b1);
    check_eq("b2b_sel2", bus.sel, 16'h0002);
    check_eq("b2b_res_valid", bus.res_valid, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    // backpressure in HOLD with a waiting op
    step(1'b1, 4'd7, 1'b0);
    repeat (5) step(1'b1, 4'd9, 1'b0);
    check_eq("bp_sel_held", bus.sel, 16'h0080);
    step(1'b1, 4'd9, 1'b1);
    check_eq("bp_new_sel", bus.sel, 16'h0200);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

`ifdef ALU_SEQ_ILLEGAL_EN
    step(1'b1, 4'd8, 1'b0);
    check_eq("ill_err", bus.err, 1'b1);
    check_eq("ill_sel", bus.sel, 16'h0000);
    check_eq("ill_res_valid", bus.res_valid, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    check_eq("ill_err_clr", bus.err, 1'b0);
    step(1'b0, 4'd0, 1'b0);
`endif

    // asynchronous reset while in EXEC
    step(1'b1, 4'd14, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("arst_sel", bus.sel, 16'h0000);
    check_eq("arst_res_valid", bus.res_valid, 1'b0);
    check_eq("arst_busy", bus.busy, 1'b0);
    m_have = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc++;
    check_eq("arst_op_ready", bus.op_ready, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic       v, rr;
      logic [3:0] code;
      v    = ($urandom_range(0, 9) < 7);
      rr   = ($urandom_range(0, 1) == 1);
      code = ($urandom_range(0, 3) == 0) ? 4'(14 + $urandom_range(0, 1))
                                         : 4'($urandom_range(0, 15));
      step(v, code, rr);
    end
    repeat (8) step(1'b0, 4'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
